// File: rtl/rs_dispatch_ctrl_pkg.sv
// Shared types for the reservation-station dispatch controller.
// R_UOp mirrors the renamed-uop layout carried from rename.
package rs_dispatch_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        RESYNC
    } RsDispState;

    localparam int unsigned RS_LSU_IDX = 0;

    typedef struct packed {
        logic [5:0] sqN;
        logic [6:0] tagDst;
        logic [4:0] opcode;
        logic [5:0] fu;
    } R_UOp;

endpackage

// File: rtl/rs_dispatch_ctrl_if.sv
// Rename-to-dispatch group bus plus the registered enqueue requests toward the stations.
interface rs_dispatch_ctrl_if
    import rs_dispatch_ctrl_pkg::*;
#(
    parameter int unsigned NUM_UOPS = 2,
    parameter int unsigned NUM_RS   = 2
) ();

    localparam int unsigned SW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    logic          IN_uopValid [NUM_UOPS];
    R_UOp          IN_uop      [NUM_UOPS];
    logic          IN_needRs0  [NUM_UOPS];
    logic          OUT_stall;
    logic          OUT_valid   [NUM_UOPS];
    R_UOp          OUT_uop     [NUM_UOPS];
    logic [SW-1:0] OUT_rsSel   [NUM_UOPS];

    modport slave (
        input  IN_uopValid, IN_uop, IN_needRs0,
        output OUT_stall, OUT_valid, OUT_uop, OUT_rsSel
    );

    modport master (
        output IN_uopValid, IN_uop, IN_needRs0,
        input  OUT_stall, OUT_valid, OUT_uop, OUT_rsSel
    );

endinterface

// File: rtl/rs_dispatch_ctrl_steer_pick.sv
// Combinational slot-to-station assignment against running copies of the credits.
// Slots are placed in order; each placement consumes one credit before the next slot looks.
module dispatch_steer_pick
    import rs_dispatch_ctrl_pkg::*;
#(
    parameter int unsigned NUM_UOPS = 2,
    parameter int unsigned NUM_RS   = 2,
    parameter int unsigned CW       = 4,
    parameter int unsigned SW       = 1
) (
    input  logic [CW-1:0] credit   [NUM_RS],
    input  logic          valid    [NUM_UOPS],
    input  logic          need_rs0 [NUM_UOPS],
    output logic [SW-1:0] sel      [NUM_UOPS],
    output logic          fits
);

    logic [CW-1:0] avail [NUM_RS];
    logic [SW-1:0] best;

    always_comb begin
        avail = credit;
        fits  = 1'b1;
        best  = '0;
        for (int unsigned i = 0; i < NUM_UOPS; i++) begin
            sel[i] = '0;
        end
        for (int unsigned i = 0; i < NUM_UOPS; i++) begin
            if (valid[i]) begin
                if (need_rs0[i]) begin
                    best = SW'(RS_LSU_IDX);
                end else begin
                    // Strict '>' keeps ties on the lower station index.
                    best = '0;
                    for (int unsigned r = 1; r < NUM_RS; r++) begin
                        if (avail[r] > avail[best]) begin
                            best = SW'(r);
                        end
                    end
                end
                if (avail[best] != '0) begin
                    sel[i]      = best;
                    avail[best] = avail[best] - CW'(1);
                end else begin
                    fits = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/rs_dispatch_ctrl.sv
// Credit-based dispatch controller: steers renamed uop groups to reservation stations,
// stalls on insufficient credit, and resynchronises credits after a branch invalidate.
module rs_dispatch_ctrl
    import rs_dispatch_ctrl_pkg::*;
#(
    parameter int unsigned NUM_UOPS     = 2,
    parameter int unsigned NUM_RS       = 2,
    parameter int unsigned RS_SIZE      = 8,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    rs_dispatch_ctrl_if.slave bus,
    input  logic [1:0]        IN_rsDeq  [NUM_RS],
    input  logic [4:0]        IN_rsFree [NUM_RS],
    input  logic              IN_invalidate,
    input  logic [5:0]        IN_invalidateSqN
);

    localparam int unsigned CW  = $clog2(RS_SIZE + 1);
    localparam int unsigned SW  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
    localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    RsDispState    state_q, state_d;
    logic [CW-1:0] credit_q [NUM_RS];
    logic [CW-1:0] credit_d [NUM_RS];
    logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
    logic          valid_q  [NUM_UOPS];
    logic          valid_d  [NUM_UOPS];
    R_UOp          uop_q    [NUM_UOPS];
    R_UOp          uop_d    [NUM_UOPS];
    logic [SW-1:0] rs_sel_q [NUM_UOPS];
    logic [SW-1:0] rs_sel_d [NUM_UOPS];

    logic [SW-1:0] sel [NUM_UOPS];
    logic          fits;
    logic          stall;
    logic          accept;
    logic [CW:0]   disp_cnt   [NUM_RS];
    logic [CW:0]   credit_sum [NUM_RS];

    // All invalidated uops are squashed wholesale, so the surviving sqN is not needed here.
    logic unused_sqn;
    assign unused_sqn = ^IN_invalidateSqN;

    dispatch_steer_pick #(
        .NUM_UOPS (NUM_UOPS),
        .NUM_RS   (NUM_RS),
        .CW       (CW),
        .SW       (SW)
    ) u_steer (
        .credit   (credit_q),
        .valid    (bus.IN_uopValid),
        .need_rs0 (bus.IN_needRs0),
        .sel      (sel),
        .fits     (fits)
    );

    always_comb begin
        stall  = !rst || (state_q != RUN) || IN_invalidate || !fits;
        accept = !stall;
    end

    always_comb begin
        for (int unsigned r = 0; r < NUM_RS; r++) begin
            disp_cnt[r] = '0;
            for (int unsigned i = 0; i < NUM_UOPS; i++) begin
                if (accept && bus.IN_uopValid[i] && (sel[i] == SW'(r))) begin
                    disp_cnt[r] = disp_cnt[r] + (CW+1)'(1);
                end
            end
            credit_sum[r] = {1'b0, credit_q[r]} + (CW+1)'(IN_rsDeq[r]) - disp_cnt[r];
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        credit_d    = credit_q;
        uop_d       = uop_q;
        rs_sel_d    = rs_sel_q;
        for (int unsigned i = 0; i < NUM_UOPS; i++) begin
            valid_d[i] = accept && bus.IN_uopValid[i];
        end
        if (accept) begin
            uop_d    = bus.IN_uop;
            rs_sel_d = sel;
        end

        case (state_q)
            RUN: begin
                for (int unsigned r = 0; r < NUM_RS; r++) begin
                    credit_d[r] = credit_sum[r][CW-1:0];
                end
                if (IN_invalidate) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FCW'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (IN_invalidate) begin
                    flush_cnt_d = FCW'(FLUSH_CYCLES - 1);
                end else if (flush_cnt_q == '0) begin
                    state_d = RESYNC;
                end else begin
                    flush_cnt_d = flush_cnt_q - FCW'(1);
                end
            end
            RESYNC: begin
                if (IN_invalidate) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FCW'(FLUSH_CYCLES - 1);
                end else begin
                    for (int unsigned r = 0; r < NUM_RS; r++) begin
                        credit_d[r] = CW'(IN_rsFree[r]);
                    end
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            for (int unsigned r = 0; r < NUM_RS; r++) begin
                credit_q[r] <= CW'(RS_SIZE);
            end
            for (int unsigned i = 0; i < NUM_UOPS; i++) begin
                valid_q[i]  <= 1'b0;
                uop_q[i]    <= '0;
                rs_sel_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            credit_q    <= credit_d;
            valid_q     <= valid_d;
            uop_q       <= uop_d;
            rs_sel_q    <= rs_sel_d;
        end
    end

    // Station deq reports must never push a credit above capacity or below zero.
    always_ff @(posedge clk) begin
        if (rst && (state_q == RUN)) begin
            for (int unsigned r = 0; r < NUM_RS; r++) begin
                assert (credit_sum[r] <= (CW+1)'(RS_SIZE));
            end
        end
    end

    assign bus.OUT_stall = stall;
    assign bus.OUT_valid = valid_q;
    assign bus.OUT_uop   = uop_q;
    assign bus.OUT_rsSel = rs_sel_q;

endmodule

// File: tb/tb_rs_dispatch_ctrl.sv
// Directed bench for rs_dispatch_ctrl: steering, credit exhaustion, partial fit,
// invalidate/resync timing and asynchronous reset during flush.
module tb_rs_dispatch_ctrl;
    import rs_dispatch_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic [1:0] rs_deq  [2];
    logic [4:0] rs_free [2];
    logic       invalidate;
    logic [5:0] invalidate_sqn;

    int checks = 0;
    int errors = 0;

    rs_dispatch_ctrl_if #(.NUM_UOPS(2), .NUM_RS(2)) bus ();

    rs_dispatch_ctrl #(
        .NUM_UOPS     (2),
        .NUM_RS       (2),
        .RS_SIZE      (8),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .IN_rsDeq         (rs_deq),
        .IN_rsFree        (rs_free),
        .IN_invalidate    (invalidate),
        .IN_invalidateSqN (invalidate_sqn)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic v1, input logic n0, input logic n1,
                         input logic [5:0] s0, input logic [5:0] s1);
        bus.IN_uopValid[0] = v0;
        bus.IN_uopValid[1] = v1;
        bus.IN_needRs0[0]  = n0;
        bus.IN_needRs0[1]  = n1;
        bus.IN_uop[0]      = '{sqN: s0, tagDst: {1'b0, s0} + 7'd1, opcode: 5'd3, fu: 6'd1};
        bus.IN_uop[1]      = '{sqN: s1, tagDst: {1'b0, s1} + 7'd1, opcode: 5'd3, fu: 6'd2};
    endtask

    task automatic chk_credits(input string tag, input logic [31:0] c0, input logic [31:0] c1);
        chk({tag, "_cr0"}, 32'(dut.credit_q[0]), c0);
        chk({tag, "_cr1"}, 32'(dut.credit_q[1]), c1);
    endtask

    initial begin
        rst            = 1'b1;
        invalidate     = 1'b0;
        invalidate_sqn = '0;
        rs_deq[0]      = '0;
        rs_deq[1]      = '0;
        rs_free[0]     = 5'd1;
        rs_free[1]     = 5'd1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
        #1 rst = 1'b0;
        #1;
        chk("rst_stall", 32'(bus.OUT_stall), 1);
        chk("rst_valid0", 32'(bus.OUT_valid[0]), 0);
        chk_credits("rst", 8, 8);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Two plain uops: tie goes to RS0, then RS1 has more.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd1, 6'd2);
        #1 chk("plain_stall", 32'(bus.OUT_stall), 0);
        tick();
        chk("plain_v0", 32'(bus.OUT_valid[0]), 1);
        chk("plain_v1", 32'(bus.OUT_valid[1]), 1);
        chk("plain_sel0", 32'(bus.OUT_rsSel[0]), 0);
        chk("plain_sel1", 32'(bus.OUT_rsSel[1]), 1);
        chk("plain_sqn0", 32'(bus.OUT_uop[0].sqN), 1);
        chk_credits("plain", 7, 7);

        // Empty group with deq refills both stations.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
        rs_deq[0] = 2'd1;
        rs_deq[1] = 2'd1;
        #1 chk("empty_stall", 32'(bus.OUT_stall), 0);
        tick();
        rs_deq[0] = 2'd0;
        rs_deq[1] = 2'd0;
        chk("empty_v0", 32'(bus.OUT_valid[0]), 0);
        chk_credits("refill", 8, 8);

        // Station-0 exhaustion.
        for (int g = 0; g < 4; g++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, 6'(10 + g), 6'(20 + g));
            #1 chk("lsu_stall", 32'(bus.OUT_stall), 0);
            tick();
            chk("lsu_sel0", 32'(bus.OUT_rsSel[0]), 0);
            chk("lsu_sel1", 32'(bus.OUT_rsSel[1]), 0);
            chk("lsu_cr0", 32'(dut.credit_q[0]), 32'(6 - 2 * g));
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 6'd15, 6'd25);
        rs_deq[0] = 2'd2;
        #1 chk("lsu_full_stall", 32'(bus.OUT_stall), 1);
        tick();
        rs_deq[0] = 2'd0;
        chk("lsu_full_v0", 32'(bus.OUT_valid[0]), 0);
        chk_credits("lsu_deq", 2, 8);
        #1 chk("lsu_retry_stall", 32'(bus.OUT_stall), 0);
        tick();
        chk("lsu_retry_v0", 32'(bus.OUT_valid[0]), 1);
        chk("lsu_retry_v1", 32'(bus.OUT_valid[1]), 1);
        chk("lsu_retry_sqn1", 32'(bus.OUT_uop[1].sqN), 25);
        chk_credits("lsu_retry", 0, 8);

        // Mixed group setup: reach credits 1/5.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd3, 6'd4);
        tick();
        chk("mix_pre_sel0", 32'(bus.OUT_rsSel[0]), 1);
        chk("mix_pre_sel1", 32'(bus.OUT_rsSel[1]), 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd5, 6'd6);
        rs_deq[0] = 2'd1;
        tick();
        rs_deq[0] = 2'd0;
        chk("mix_pre_v1", 32'(bus.OUT_valid[1]), 0);
        chk_credits("mix_pre", 1, 5);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 6'd20, 6'd21);
        #1 chk("mix_stall", 32'(bus.OUT_stall), 0);
        tick();
        chk("mix_sel0", 32'(bus.OUT_rsSel[0]), 1);
        chk("mix_sel1", 32'(bus.OUT_rsSel[1]), 0);
        chk_credits("mix", 0, 4);

        // Partial fit: reach credits 0/1, then a two-uop group cannot be placed.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd7, 6'd8);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd9, 6'd0);
        tick();
        chk_credits("part_pre", 0, 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd30, 6'd31);
        #1 chk("part_stall", 32'(bus.OUT_stall), 1);
        tick();
        chk("part_v0", 32'(bus.OUT_valid[0]), 0);
        chk_credits("part", 0, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd30, 6'd0);
        #1 chk("part_one_stall", 32'(bus.OUT_stall), 0);
        tick();
        chk("part_one_v0", 32'(bus.OUT_valid[0]), 1);
        chk("part_one_sel0", 32'(bus.OUT_rsSel[0]), 1);
        chk_credits("part_one", 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
        #1 chk("none_stall", 32'(bus.OUT_stall), 0);
        tick();
        chk("none_v0", 32'(bus.OUT_valid[0]), 0);
        chk("none_v1", 32'(bus.OUT_valid[1]), 0);

        // Invalidate in cycle N; RESYNC at N+3 loads rsFree; accept at N+4.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd40, 6'd41);
        invalidate = 1'b1;
        #1 chk("inv_n_stall", 32'(bus.OUT_stall), 1);
        tick();
        invalidate = 1'b0;
        #1 chk("inv_n1_stall", 32'(bus.OUT_stall), 1);
        chk("inv_n1_v0", 32'(bus.OUT_valid[0]), 0);
        chk("inv_n1_state", 32'(dut.state_q), 32'(FLUSH));
        tick();
        chk("inv_n2_stall", 32'(bus.OUT_stall), 1);
        tick();
        rs_free[0] = 5'd6;
        rs_free[1] = 5'd3;
        #1 chk("inv_n3_stall", 32'(bus.OUT_stall), 1);
        chk("inv_n3_state", 32'(dut.state_q), 32'(RESYNC));
        tick();
        rs_free[0] = 5'd1;
        rs_free[1] = 5'd1;
        chk_credits("resync", 6, 3);
        #1 chk("inv_n4_stall", 32'(bus.OUT_stall), 0);
        tick();
        chk("resync_v0", 32'(bus.OUT_valid[0]), 1);
        chk("resync_sel0", 32'(bus.OUT_rsSel[0]), 0);
        chk("resync_sel1", 32'(bus.OUT_rsSel[1]), 0);
        chk("resync_sqn0", 32'(bus.OUT_uop[0].sqN), 40);
        chk_credits("post_resync", 4, 3);

        // Asynchronous reset while in FLUSH.
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        chk("ar_state_flush", 32'(dut.state_q), 32'(FLUSH));
        rst = 1'b0;
        #1;
        chk("ar_state", 32'(dut.state_q), 32'(RUN));
        chk_credits("ar", 8, 8);
        chk("ar_sqn0", 32'(bus.OUT_uop[0].sqN), 0);
        chk("ar_stall", 32'(bus.OUT_stall), 1);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd50, 6'd51);
        #1 chk("ar_run_stall", 32'(bus.OUT_stall), 0);
        tick();
        chk("ar_run_sel0", 32'(bus.OUT_rsSel[0]), 0);
        chk("ar_run_sel1", 32'(bus.OUT_rsSel[1]), 1);
        chk("ar_run_v1", 32'(bus.OUT_valid[1]), 1);
        chk_credits("ar_run", 7, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
